// File: rtl/mealy_pattern_fsm_pkg.sv
// mealy_pattern_fsm_pkg: shared state encoding and saturation constant for the pattern detector
package mealy_fsm_pkg;
  typedef enum logic [1:0] {Idle = 2'h0, Track = 2'h1, Locked = 2'h2} pattern_state_t;
  localparam bit SAT_ONES = 1'b1;
endpackage

// File: rtl/mealy_pattern_fsm_sat_counter.sv
// sat_counter: saturating up-counter with sync clear; ports clk, rst_n (async low), clr, inc, count
module sat_counter
  import mealy_fsm_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);
  localparam logic [CNT_W-1:0] MAX = {CNT_W{SAT_ONES}};
  logic [CNT_W-1:0] count_q, count_d;
  always_comb count_d = clr ? '0 : (inc && count_q != MAX) ? count_q + CNT_W'(1) : count_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count_q <= '0;
    else count_q <= count_d;
  assign count = count_q;
endmodule

// File: rtl/mealy_pattern_fsm.sv
// mealy_pattern_fsm: Mealy detector for a LEN-symbol pattern; ports clk, rst_n, clear, in_valid, in -> hit, progress, state, hit_count
module mealy_pattern_fsm
  import mealy_fsm_pkg::*;
#(
  parameter int                    WIDTH    = 2,
  parameter int                    LEN      = 3,
  parameter logic [WIDTH*LEN-1:0]  PATTERN  = 6'h39,
  parameter int                    OVERLAP  = 0,
  parameter int                    MAX_HITS = 0,
  parameter int                    CNT_W    = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    in_valid,
  input  logic [WIDTH-1:0]        in,
  output logic                    hit,
  output logic [$clog2(LEN)-1:0]  progress,
  output pattern_state_t          state,
  output logic [CNT_W-1:0]        hit_count
);
  localparam int PW = $clog2(LEN);
  localparam logic [PW-1:0] LAST = PW'(LEN - 1);
  localparam logic [WIDTH-1:0] SYM0 = PATTERN[0 +: WIDTH];
  localparam logic [WIDTH-1:0] SYML = PATTERN[(LEN-1)*WIDTH +: WIDTH];
  // progress to resume from after a completed match
  localparam logic [PW-1:0] RESUME = (OVERLAP != 0 && SYML == SYM0) ? PW'(1) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{SAT_ONES}};
  pattern_state_t state_q, state_d;
  logic [PW-1:0] prog_q, prog_d;
  logic done, lock_now, first;
  logic [CNT_W-1:0] cnt_nxt;
  function automatic logic [WIDTH-1:0] sym(input logic [PW-1:0] p);
    return PATTERN[int'(p)*WIDTH +: WIDTH];
  endfunction
  function automatic logic mealy_out(input logic complete, input logic clr);
    return complete && !clr;
  endfunction
  assign cnt_nxt  = (hit_count == CNT_MAX) ? hit_count : hit_count + CNT_W'(1);
  assign lock_now = (MAX_HITS > 0) && (cnt_nxt == CNT_W'(MAX_HITS));
  assign first    = (in == SYM0);
  always_comb begin
    state_d = state_q;
    prog_d  = prog_q;
    done    = 1'b0;
    hit     = 1'b0;
    unique case (state_q)
      Locked: ;
      Idle, Track:
        if (in_valid) begin
          if (in == sym(prog_q)) begin
            if (prog_q == LAST) begin
              done    = 1'b1;
              prog_d  = lock_now ? '0 : RESUME;
              state_d = lock_now ? Locked : (RESUME == '0) ? Idle : Track;
            end else begin
              prog_d  = prog_q + PW'(1);
              state_d = Track;
            end
          end else begin
            prog_d  = first ? PW'(1) : '0;
            state_d = first ? Track : Idle;
          end
        end
      default: begin
        state_d = Idle;
        prog_d  = '0;
      end
    endcase
    if (clear) begin
      state_d = Idle;
      prog_d  = '0;
    end
    hit = mealy_out(done, clear);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= Idle;
      prog_q  <= '0;
    end else begin
      state_q <= state_d;
      prog_q  <= prog_d;
    end
  sat_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clear),
    .inc  (hit),
    .count(hit_count)
  );
  assign progress = prog_q;
  assign state    = state_q;
endmodule
